// File: rtl/mem_stage.sv
// RV32 memory-access stage: req/gnt/rvalid data bus, byte-lane steering, load extension.
// Optional MEM_MISALIGN_CHECK_EN: misaligned half/word accesses retire without a bus access.
module mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid_i,
  input  logic              mem_mem_en_i,
  input  logic              mem_mem_rw_i,
  input  logic [DATA_W-1:0] mem_mem_addr_i,
  input  logic [DATA_W-1:0] mem_mem_data_i,
  input  logic [1:0]        mem_mem_size_i,
  input  logic              mem_mem_unsigned_i,
  input  logic [REG_AW-1:0] mem_gprs_waddr_i,
  output logic              mem_stall_o,
  output logic              dbus_req_o,
  output logic              dbus_we_o,
  output logic [DATA_W-1:0] dbus_addr_o,
  output logic [DATA_W-1:0] dbus_wdata_o,
  output logic [3:0]        dbus_be_o,
  input  logic              dbus_gnt_i,
  input  logic              dbus_rvalid_i,
  input  logic [DATA_W-1:0] dbus_rdata_i,
`ifdef MEM_MISALIGN_CHECK_EN
  output logic              mem_misaligned_o,
`endif
  output logic              wb_valid_o,
  output logic              wb_gprs_we_o,
  output logic [REG_AW-1:0] wb_gprs_waddr_o,
  output logic [DATA_W-1:0] wb_gprs_wdata_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t            state;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [1:0]        off_q;
  logic [REG_AW-1:0] waddr_q;

  logic [DATA_W-1:0] st_wdata;
  logic [3:0]        st_be;
  logic [DATA_W-1:0] ld_shift_b;
  logic [DATA_W-1:0] ld_shift_h;
  logic [DATA_W-1:0] ld_data;
  logic              misal;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misal = (mem_mem_size_i == 2'b01 && mem_mem_addr_i[0]) ||
                 (mem_mem_size_i[1] && mem_mem_addr_i[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif

  // Store steering from the live inputs; values are latched on acceptance.
  always_comb begin
    st_wdata = '0;
    st_be    = 4'b1111;
    if (mem_mem_rw_i) begin
      case (mem_mem_size_i)
        2'b00: begin
          st_wdata = {4{mem_mem_data_i[7:0]}};
          st_be    = 4'b0001 << mem_mem_addr_i[1:0];
        end
        2'b01: begin
          st_wdata = {2{mem_mem_data_i[15:0]}};
          st_be    = 4'b0011 << {mem_mem_addr_i[1], 1'b0};
        end
        default: begin
          st_wdata = mem_mem_data_i;
          st_be    = 4'b1111;
        end
      endcase
    end
  end

  assign ld_shift_b = dbus_rdata_i >> {off_q, 3'b000};
  assign ld_shift_h = dbus_rdata_i >> {off_q[1], 4'b0000};

  always_comb begin
    ld_data = dbus_rdata_i;
    case (size_q)
      2'b00: ld_data = uns_q ? {{(DATA_W-8){1'b0}}, ld_shift_b[7:0]}
                             : {{(DATA_W-8){ld_shift_b[7]}}, ld_shift_b[7:0]};
      2'b01: ld_data = uns_q ? {{(DATA_W-16){1'b0}}, ld_shift_h[15:0]}
                             : {{(DATA_W-16){ld_shift_h[15]}}, ld_shift_h[15:0]};
      default: ld_data = dbus_rdata_i;
    endcase
  end

  always_comb begin
    mem_stall_o = 1'b0;
    case (state)
      IDLE:    mem_stall_o = mem_valid_i && mem_mem_en_i && !misal;
      REQ:     mem_stall_o = 1'b1;
      RESP:    mem_stall_o = !dbus_rvalid_i;
      default: mem_stall_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      size_q          <= '0;
      uns_q           <= 1'b0;
      off_q           <= '0;
      waddr_q         <= '0;
      dbus_req_o      <= 1'b0;
      dbus_we_o       <= 1'b0;
      dbus_addr_o     <= '0;
      dbus_wdata_o    <= '0;
      dbus_be_o       <= '0;
      wb_valid_o      <= 1'b0;
      wb_gprs_we_o    <= 1'b0;
      wb_gprs_waddr_o <= '0;
      wb_gprs_wdata_o <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
      mem_misaligned_o <= 1'b0;
`endif
    end else begin
      wb_valid_o <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      mem_misaligned_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (mem_valid_i && mem_mem_en_i && misal) begin
            wb_valid_o      <= 1'b1;
            wb_gprs_we_o    <= 1'b0;
            wb_gprs_waddr_o <= mem_gprs_waddr_i;
`ifdef MEM_MISALIGN_CHECK_EN
            mem_misaligned_o <= 1'b1;
`endif
          end else if (mem_valid_i && mem_mem_en_i) begin
            dbus_req_o   <= 1'b1;
            dbus_we_o    <= mem_mem_rw_i;
            dbus_addr_o  <= {mem_mem_addr_i[DATA_W-1:2], 2'b00};
            dbus_wdata_o <= st_wdata;
            dbus_be_o    <= st_be;
            size_q       <= mem_mem_size_i;
            uns_q        <= mem_mem_unsigned_i;
            off_q        <= mem_mem_addr_i[1:0];
            waddr_q      <= mem_gprs_waddr_i;
            state        <= REQ;
          end else if (mem_valid_i) begin
            wb_valid_o      <= 1'b1;
            wb_gprs_we_o    <= (mem_gprs_waddr_i != '0);
            wb_gprs_waddr_o <= mem_gprs_waddr_i;
            wb_gprs_wdata_o <= mem_mem_data_i;
          end
        end
        REQ: begin
          if (dbus_gnt_i) begin
            dbus_req_o <= 1'b0;
            state      <= RESP;
          end
        end
        RESP: begin
          if (dbus_rvalid_i) begin
            wb_valid_o      <= 1'b1;
            wb_gprs_we_o    <= !dbus_we_o && (waddr_q != '0);
            wb_gprs_waddr_o <= waddr_q;
            if (!dbus_we_o) wb_gprs_wdata_o <= ld_data;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; checks are immediate assertions.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_i, mem_mem_en_i, mem_mem_rw_i, mem_mem_unsigned_i;
  logic [31:0] mem_mem_addr_i, mem_mem_data_i;
  logic [1:0]  mem_mem_size_i;
  logic [4:0]  mem_gprs_waddr_i;
  logic        mem_stall_o, dbus_req_o, dbus_we_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o;
  logic [3:0]  dbus_be_o;
  logic        dbus_gnt_i, dbus_rvalid_i;
  logic [31:0] dbus_rdata_i;
  logic        wb_valid_o, wb_gprs_we_o;
  logic [4:0]  wb_gprs_waddr_o;
  logic [31:0] wb_gprs_wdata_o;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        mem_misaligned_o;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic        cap_req, cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;

  always #5 clk = ~clk;

  mem_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst),
    .mem_valid_i(mem_valid_i), .mem_mem_en_i(mem_mem_en_i), .mem_mem_rw_i(mem_mem_rw_i),
    .mem_mem_addr_i(mem_mem_addr_i), .mem_mem_data_i(mem_mem_data_i),
    .mem_mem_size_i(mem_mem_size_i), .mem_mem_unsigned_i(mem_mem_unsigned_i),
    .mem_gprs_waddr_i(mem_gprs_waddr_i), .mem_stall_o(mem_stall_o),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_wdata_o(dbus_wdata_o), .dbus_be_o(dbus_be_o), .dbus_gnt_i(dbus_gnt_i),
    .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i),
`ifdef MEM_MISALIGN_CHECK_EN
    .mem_misaligned_o(mem_misaligned_o),
`endif
    .wb_valid_o(wb_valid_o), .wb_gprs_we_o(wb_gprs_we_o),
    .wb_gprs_waddr_o(wb_gprs_waddr_o), .wb_gprs_wdata_o(wb_gprs_wdata_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive new inputs shortly after the edge, sample 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One memory op: gnt on the first REQ cycle, rvalid on the first RESP cycle.
  task automatic op(input logic rw, input logic [31:0] a, input logic [31:0] d,
                    input logic [1:0] sz, input logic u, input logic [4:0] wa,
                    input logic [31:0] rd);
    cyc();
    mem_valid_i = 1'b1; mem_mem_en_i = 1'b1; mem_mem_rw_i = rw;
    mem_mem_addr_i = a; mem_mem_data_i = d; mem_mem_size_i = sz;
    mem_mem_unsigned_i = u; mem_gprs_waddr_i = wa;
    cyc();
    #1;
    cap_req = dbus_req_o; cap_we = dbus_we_o; cap_addr = dbus_addr_o;
    cap_wdata = dbus_wdata_o; cap_be = dbus_be_o;
    dbus_gnt_i = 1'b1;
    cyc();
    dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b1; dbus_rdata_i = rd;
    cyc();
    dbus_rvalid_i = 1'b0; mem_valid_i = 1'b0; mem_mem_en_i = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    mem_valid_i = 1'b0; mem_mem_en_i = 1'b0; mem_mem_rw_i = 1'b0;
    mem_mem_addr_i = '0; mem_mem_data_i = '0; mem_mem_size_i = '0;
    mem_mem_unsigned_i = 1'b0; mem_gprs_waddr_i = '0;
    dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = '0;
    cyc(); cyc();
    #1;
    chk("rst_req", {31'b0, dbus_req_o}, 32'd0);
    chk("rst_stall", {31'b0, mem_stall_o}, 32'd0);
    chk("rst_wbv", {31'b0, wb_valid_o}, 32'd0);
    chk("rst_wdata", wb_gprs_wdata_o, 32'd0);
    chk("rst_addr", dbus_addr_o, 32'd0);
    rst = 1'b0;

    // LW 0x100 -> x5, gnt one cycle after req, rvalid two cycles after gnt
    cyc();
    mem_valid_i = 1'b1; mem_mem_en_i = 1'b1; mem_mem_rw_i = 1'b0;
    mem_mem_addr_i = 32'h100; mem_mem_size_i = 2'b10; mem_gprs_waddr_i = 5'd5;
    #1;
    chk("lw_c0_stall", {31'b0, mem_stall_o}, 32'd1);
    chk("lw_c0_req", {31'b0, dbus_req_o}, 32'd0);
    cyc(); #1;
    chk("lw_c1_stall", {31'b0, mem_stall_o}, 32'd1);
    chk("lw_c1_req", {31'b0, dbus_req_o}, 32'd1);
    chk("lw_addr", dbus_addr_o, 32'h100);
    chk("lw_be", {28'b0, dbus_be_o}, 32'hF);
    chk("lw_we", {31'b0, dbus_we_o}, 32'd0);
    cyc(); dbus_gnt_i = 1'b1; #1;
    chk("lw_c2_stall", {31'b0, mem_stall_o}, 32'd1);
    chk("lw_c2_req", {31'b0, dbus_req_o}, 32'd1);
    cyc(); dbus_gnt_i = 1'b0; #1;
    chk("lw_c3_stall", {31'b0, mem_stall_o}, 32'd1);
    chk("lw_c3_req", {31'b0, dbus_req_o}, 32'd0);
    chk("lw_c3_wbv", {31'b0, wb_valid_o}, 32'd0);
    cyc(); dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'hDEADBEEF; #1;
    chk("lw_c4_stall", {31'b0, mem_stall_o}, 32'd0);
    cyc(); dbus_rvalid_i = 1'b0; mem_valid_i = 1'b0; mem_mem_en_i = 1'b0; #1;
    chk("lw_wbv", {31'b0, wb_valid_o}, 32'd1);
    chk("lw_wbwe", {31'b0, wb_gprs_we_o}, 32'd1);
    chk("lw_waddr", {27'b0, wb_gprs_waddr_o}, 32'd5);
    chk("lw_wdata", wb_gprs_wdata_o, 32'hDEADBEEF);
    cyc(); #1;
    chk("lw_wbv_pulse", {31'b0, wb_valid_o}, 32'd0);

    // Load extraction
    op(1'b0, 32'h103, 32'h0, 2'b00, 1'b0, 5'd6, 32'h80123456);
    chk("lb_addr", cap_addr, 32'h100);
    chk("lb_be", {28'b0, cap_be}, 32'hF);
    chk("lb_wdata", wb_gprs_wdata_o, 32'hFFFFFF80);
    op(1'b0, 32'h103, 32'h0, 2'b00, 1'b1, 5'd6, 32'h80123456);
    chk("lbu_wdata", wb_gprs_wdata_o, 32'h00000080);
    op(1'b0, 32'h101, 32'h0, 2'b00, 1'b0, 5'd6, 32'h80123456);
    chk("lb1_wdata", wb_gprs_wdata_o, 32'h00000034);
    op(1'b0, 32'h102, 32'h0, 2'b01, 1'b0, 5'd7, 32'h8001ABCD);
    chk("lh_wdata", wb_gprs_wdata_o, 32'hFFFF8001);
    op(1'b0, 32'h100, 32'h0, 2'b01, 1'b0, 5'd7, 32'h8001ABCD);
    chk("lh0_wdata", wb_gprs_wdata_o, 32'hFFFFABCD);
    op(1'b0, 32'h100, 32'h0, 2'b01, 1'b1, 5'd7, 32'h8001ABCD);
    chk("lhu_wdata", wb_gprs_wdata_o, 32'h0000ABCD);
    op(1'b0, 32'h104, 32'h0, 2'b11, 1'b1, 5'd0, 32'h8001ABCD);
    chk("lw_x0_we", {31'b0, wb_gprs_we_o}, 32'd0);
    chk("lw11_wdata", wb_gprs_wdata_o, 32'h8001ABCD);

    // Stores
    op(1'b1, 32'h201, 32'h000000AB, 2'b00, 1'b0, 5'd9, 32'h0);
    chk("sb_req", {31'b0, cap_req}, 32'd1);
    chk("sb_we", {31'b0, cap_we}, 32'd1);
    chk("sb_addr", cap_addr, 32'h200);
    chk("sb_be", {28'b0, cap_be}, 32'h2);
    chk("sb_wdata", cap_wdata, 32'hABABABAB);
    chk("sb_wbv", {31'b0, wb_valid_o}, 32'd1);
    chk("sb_wbwe", {31'b0, wb_gprs_we_o}, 32'd0);
    op(1'b1, 32'h202, 32'h1234CAFE, 2'b01, 1'b0, 5'd9, 32'h0);
    chk("sh_be", {28'b0, cap_be}, 32'hC);
    chk("sh_wdata", cap_wdata, 32'hCAFECAFE);
    op(1'b1, 32'h204, 32'h11223344, 2'b10, 1'b0, 5'd9, 32'h0);
    chk("sw_addr", cap_addr, 32'h204);
    chk("sw_be", {28'b0, cap_be}, 32'hF);
    chk("sw_wdata", cap_wdata, 32'h11223344);

    // Pass-through, back to back, second one targets x0
    cyc();
    mem_valid_i = 1'b1; mem_mem_en_i = 1'b0; mem_mem_data_i = 32'h1234; mem_gprs_waddr_i = 5'd3;
    #1;
    chk("pt_stall", {31'b0, mem_stall_o}, 32'd0);
    chk("pt_req", {31'b0, dbus_req_o}, 32'd0);
    cyc();
    mem_mem_data_i = 32'h5678; mem_gprs_waddr_i = 5'd0;
    #1;
    chk("pt_wbv", {31'b0, wb_valid_o}, 32'd1);
    chk("pt_wbwe", {31'b0, wb_gprs_we_o}, 32'd1);
    chk("pt_waddr", {27'b0, wb_gprs_waddr_o}, 32'd3);
    chk("pt_wdata", wb_gprs_wdata_o, 32'h1234);
    cyc();
    mem_valid_i = 1'b0;
    #1;
    chk("pt0_wbv", {31'b0, wb_valid_o}, 32'd1);
    chk("pt0_wbwe", {31'b0, wb_gprs_we_o}, 32'd0);
    chk("pt0_wdata", wb_gprs_wdata_o, 32'h5678);
    cyc(); #1;
    chk("pt_idle_wbv", {31'b0, wb_valid_o}, 32'd0);

    // Reset while in RESP, then a stray rvalid
    cyc();
    mem_valid_i = 1'b1; mem_mem_en_i = 1'b1; mem_mem_rw_i = 1'b0;
    mem_mem_addr_i = 32'h300; mem_mem_size_i = 2'b10; mem_gprs_waddr_i = 5'd4;
    cyc(); dbus_gnt_i = 1'b1;
    cyc(); dbus_gnt_i = 1'b0; rst = 1'b1; #1;
    chk("rr_in_resp_stall", {31'b0, mem_stall_o}, 32'd1);
    cyc(); rst = 1'b0; mem_valid_i = 1'b0; mem_mem_en_i = 1'b0;
    dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'hCAFEF00D; #1;
    chk("rr_req", {31'b0, dbus_req_o}, 32'd0);
    chk("rr_stall", {31'b0, mem_stall_o}, 32'd0);
    chk("rr_wbv0", {31'b0, wb_valid_o}, 32'd0);
    cyc(); dbus_rvalid_i = 1'b0; #1;
    chk("rr_wbv1", {31'b0, wb_valid_o}, 32'd0);
    chk("rr_wdata", wb_gprs_wdata_o, 32'd0);

`ifdef MEM_MISALIGN_CHECK_EN
    cyc();
    mem_valid_i = 1'b1; mem_mem_en_i = 1'b1; mem_mem_rw_i = 1'b0;
    mem_mem_addr_i = 32'h102; mem_mem_size_i = 2'b10; mem_gprs_waddr_i = 5'd8;
    #1;
    chk("mis_stall", {31'b0, mem_stall_o}, 32'd0);
    cyc(); mem_valid_i = 1'b0; mem_mem_en_i = 1'b0; #1;
    chk("mis_req", {31'b0, dbus_req_o}, 32'd0);
    chk("mis_wbv", {31'b0, wb_valid_o}, 32'd1);
    chk("mis_flag", {31'b0, mem_misaligned_o}, 32'd1);
    chk("mis_we", {31'b0, wb_gprs_we_o}, 32'd0);
    cyc(); #1;
    chk("mis_flag_pulse", {31'b0, mem_misaligned_o}, 32'd0);
    chk("mis_req2", {31'b0, dbus_req_o}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
